jtpopeye_objdma: RTL and testbench
==================================

JTPOPEYE_OBJDMA -- requirements
Module: jtpopeye_objdma

Interface
REQ-001 The parameter OBJ_BASE, default 10'h000, SHALL set the CPU-RAM word address of object-table byte 0.
REQ-002 The parameter OBJ_LEN, default 9'd160, SHALL set the bytes copied per frame (40 objects x 4 bytes); legal range is 1..256.
REQ-003 The input clk, 1 bit, SHALL be the system clock; all state SHALL change on its rising edge.
REQ-004 The input rst_n, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-005 The input pxl_cen, 1 bit, SHALL be the pixel clock enable; all state other than reset SHALL advance only when it is high.
REQ-006 The input VB, 1 bit, SHALL be vertical blank from the timing block.
REQ-007 The input HBD_n, 1 bit, SHALL be the horizontal-blank DMA window; 0 means a transfer is permitted.
REQ-008 The input busak_n, 1 bit, SHALL be the CPU bus acknowledge, active-low.
REQ-009 The output busrq_n, 1 bit, SHALL be the CPU bus request, active-low.
REQ-010 The output dma_addr, 10 bits, SHALL be the CPU-RAM read address.
REQ-011 The input dma_din, 8 bits, SHALL be the CPU-RAM read data, valid one enabled cycle after dma_addr.
REQ-012 The output obj_addr, 8 bits, SHALL be the object-buffer write address.
REQ-013 The output obj_dout, 8 bits, SHALL be the object-buffer write data.
REQ-014 The output obj_we, 1 bit, SHALL be the object-buffer write strobe; it is active for one enabled cycle per byte.
REQ-015 The output DM10, 1 bit, SHALL be high while a transfer is in state XFER; it feeds the interleaving logic.
REQ-016 The output dma_abort, 1 bit, SHALL pulse for one enabled cycle when a transfer is cut short.

Function
REQ-017 The block SHALL implement the FSM states IDLE, REQ, XFER and REL.
REQ-018 In IDLE, when a rising edge of VB is detected (current VB=1, VB registered on the previous enabled cycle = 0), the FSM SHALL go to REQ and drive busrq_n=0.
REQ-019 In REQ, when busak_n=0, the FSM SHALL go to XFER, clear the byte counter cnt (9 bits) and set DM10=1; while busak_n=1 it SHALL wait with no timeout.
REQ-020 In XFER, on each enabled cycle with HBD_n=0 and busak_n=0, the block SHALL issue dma_addr=OBJ_BASE+cnt (10-bit wrap) and increment cnt.
REQ-021 Otherwise in XFER, cnt and dma_addr SHALL hold.
REQ-022 Write pipeline: one enabled cycle after each issued read, the block SHALL drive obj_we=1, obj_addr equal to the issued cnt[7:0] and obj_dout=dma_din.
REQ-023 The write pipeline SHALL complete even if HBD_n rises in that cycle.
REQ-024 When the read with cnt=OBJ_LEN-1 has been issued, no further reads SHALL be issued; once its write completes, the FSM SHALL go to REL.
REQ-025 In REL, the block SHALL drive busrq_n=1 and DM10=0, then go to IDLE on the next enabled cycle.
REQ-026 A VB falling edge in REQ or XFER SHALL force REL, pulse dma_abort and suppress any further reads; a pending write SHALL still complete.
REQ-027 A VB rising edge detected outside IDLE SHALL be ignored, so there is at most one transfer per frame.
REQ-028 A busak_n rise during XFER SHALL pause the transfer (hold, no reads) without aborting it; a write already in the pipeline SHALL still complete.
REQ-029 obj_we SHALL be 0 in every cycle in which no write is pending.
REQ-030 obj_addr and obj_dout SHALL hold their last values between writes.

Reset
REQ-031 While rst_n=0, the block SHALL hold: FSM=IDLE, busrq_n=1, DM10=0, obj_we=0, dma_abort=0, cnt=0, dma_addr=OBJ_BASE, obj_addr=0, obj_dout=0, registered VB=0.
REQ-032 Reset asserted mid-transfer SHALL release the bus immediately and asynchronously, without waiting for clk.
REQ-033 After reset release with VB already 1, the block SHALL start a transfer, because the registered VB is 0.

Verification
REQ-034 The bench SHALL check a normal frame: VB 0->1, busak_n low 3 cycles later, HBD_n held 0 -> busrq_n falls 1 enabled cycle after the VB edge; exactly 160 obj_we pulses with obj_addr 0..159 and obj_dout matching RAM[OBJ_BASE+n]; then busrq_n=1 and DM10=0.
REQ-035 The bench SHALL check a windowed transfer: HBD_n toggling 8 cycles low / 56 high -> at most 8 reads per window; all 160 bytes are correct and in order; no write occurs more than 1 enabled cycle after a window closes.
REQ-036 The bench SHALL check an abort: VB falls after the 50th read -> 50 writes, one dma_abort pulse, busrq_n=1 on the next enabled cycle, FSM returns to IDLE.
REQ-037 The bench SHALL check a late acknowledge: busak_n held high through the whole VB period -> no obj_we pulses; dma_abort pulses at VB fall; busrq_n returns to 1.
REQ-038 The bench SHALL check reset mid-XFER: rst_n pulsed low -> busrq_n=1 and obj_we=0 within the same clk period; with VB still high after release, a fresh transfer starts from obj_addr 0.
REQ-039 The bench SHALL check the boundary: OBJ_LEN=256 with OBJ_BASE=10'h3C0 -> dma_addr wraps from 10'h3FF to 10'h000 and the final write has obj_addr=255.

Source files
------------

// File: rtl/jtpopeye_objdma.sv
// jtpopeye_objdma: copies the CPU object table into the object buffer
// once per frame, borrowing the CPU bus inside horizontal-blank windows.
module jtpopeye_objdma #(
    parameter logic [9:0] OBJ_BASE = 10'h000,
    parameter logic [8:0] OBJ_LEN  = 9'd160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       VB,
    input  logic       HBD_n,
    input  logic       busak_n,
    output logic       busrq_n,
    output logic [9:0] dma_addr,
    input  logic [7:0] dma_din,
    output logic [7:0] obj_addr,
    output logic [7:0] obj_dout,
    output logic       obj_we,
    output logic       DM10,
    output logic       dma_abort
);

    typedef enum logic [1:0] { IDLE, REQ, XFER, REL } state_t;

    state_t     st;
    state_t     st_nx;
    logic       vb_r;
    logic       vb_rise;
    logic       vb_fall;
    logic       done;
    logic       rd_en;
    logic       abort;
    logic       wr_pend;
    logic [8:0] cnt;
    logic [7:0] wr_addr;

    assign vb_rise = VB & ~vb_r;
    assign vb_fall = ~VB & vb_r;
    assign done    = (cnt == OBJ_LEN);

    // Bus request and DM10 decode straight from state, so an async
    // reset drops the request without waiting for a clock edge.
    assign busrq_n = ~((st == REQ) | (st == XFER));
    assign DM10    = (st == XFER);

    // Next-state, read-issue and abort decisions
    always_comb begin
        st_nx = st;
        rd_en = 1'b0;
        abort = 1'b0;
        unique case (st)
            IDLE: begin
                if (vb_rise) st_nx = REQ;
            end
            REQ: begin
                if (vb_fall) begin
                    st_nx = REL;
                    abort = 1'b1;
                end else if (!busak_n) begin
                    st_nx = XFER;
                end
            end
            XFER: begin
                if (done) begin
                    st_nx = REL;
                end else if (vb_fall) begin
                    st_nx = REL;
                    abort = 1'b1;
                end else begin
                    rd_en = ~HBD_n & ~busak_n;
                end
            end
            REL: begin
                st_nx = IDLE;
            end
            default: st_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
        end else if (pxl_cen) begin
            st <= st_nx;
        end
    end

    // Read side: VB history, byte counter and RAM address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vb_r     <= 1'b0;
            cnt      <= 9'd0;
            dma_addr <= OBJ_BASE;
            wr_pend  <= 1'b0;
            wr_addr  <= 8'd0;
        end else if (pxl_cen) begin
            vb_r    <= VB;
            wr_pend <= rd_en;
            if (st == REQ) cnt <= 9'd0;
            if (rd_en) begin
                cnt      <= cnt + 9'd1;
                dma_addr <= OBJ_BASE + {1'b0, cnt};
                wr_addr  <= cnt[7:0];
            end
        end
    end

    // Write side: one stage behind each read, independent of the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obj_we    <= 1'b0;
            obj_addr  <= 8'd0;
            obj_dout  <= 8'd0;
            dma_abort <= 1'b0;
        end else if (pxl_cen) begin
            obj_we    <= wr_pend;
            dma_abort <= abort;
            if (wr_pend) begin
                obj_addr <= wr_addr;
                obj_dout <= dma_din;
            end
        end
    end

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// tb_jtpopeye_objdma: vector table, directed frames and random frames
// on two instances (default and wrapping 256-byte configuration).
module tb_jtpopeye_objdma;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl_cen = 1'b1;
    logic       VB = 1'b0;
    logic       HBD_n = 1'b1;
    logic       busak_n = 1'b1;
    logic [1:0] busrq_n_w;
    logic [1:0] obj_we_w;
    logic [1:0] dm10_w;
    logic [1:0] abort_w;
    logic [9:0] dma_addr_w [2];
    logic [7:0] dma_din_w [2];
    logic [7:0] obj_addr_w [2];
    logic [7:0] obj_dout_w [2];
    logic [7:0] ram [1024];

    int checks = 0;
    int failures = 0;
    bit gap_en = 1'b0;
    bit win_mode = 1'b0;
    int base_a [2] = '{0, 960};
    int len_a [2] = '{160, 256};

    // reference model: transfer-level view of each instance
    bit m_vb [2];
    bit want [2];
    bit own [2];
    bit closing [2];
    int iss [2];
    bit pend [2];
    int pend_a [2];
    int e_da [2];
    int e_oa [2];
    int e_od [2];
    bit e_we [2];
    bit e_ab [2];

    // observed statistics
    int wr_cnt [2];
    int xfer_wr [2];
    int abort_cnt [2];
    bit wrap [2];
    int prev_da [2];
    int first_wa [2];
    int hi_run;
    int win_wr;

    typedef struct {
        logic vb;
        logic hbd_n;
        logic busak_n;
        logic busrq_n;
        logic dm10;
        logic we;
        logic abort;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    assign dma_din_w[0] = ram[dma_addr_w[0]];
    assign dma_din_w[1] = ram[dma_addr_w[1]];

    jtpopeye_objdma u0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .VB       (VB),
        .HBD_n    (HBD_n),
        .busak_n  (busak_n),
        .busrq_n  (busrq_n_w[0]),
        .dma_addr (dma_addr_w[0]),
        .dma_din  (dma_din_w[0]),
        .obj_addr (obj_addr_w[0]),
        .obj_dout (obj_dout_w[0]),
        .obj_we   (obj_we_w[0]),
        .DM10     (dm10_w[0]),
        .dma_abort(abort_w[0])
    );

    jtpopeye_objdma #(
        .OBJ_BASE(10'h3C0),
        .OBJ_LEN (9'd256)
    ) u1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .VB       (VB),
        .HBD_n    (HBD_n),
        .busak_n  (busak_n),
        .busrq_n  (busrq_n_w[1]),
        .dma_addr (dma_addr_w[1]),
        .dma_din  (dma_din_w[1]),
        .obj_addr (obj_addr_w[1]),
        .obj_dout (obj_dout_w[1]),
        .obj_we   (obj_we_w[1]),
        .DM10     (dm10_w[1]),
        .dma_abort(abort_w[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s actual=%0d required=%0d @%0t",
                         nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_vb[i] = 1'b0;
            want[i] = 1'b0;
            own[i] = 1'b0;
            closing[i] = 1'b0;
            iss[i] = 0;
            pend[i] = 1'b0;
            pend_a[i] = 0;
            e_da[i] = base_a[i];
            e_oa[i] = 0;
            e_od[i] = 0;
            e_we[i] = 1'b0;
            e_ab[i] = 1'b0;
        end
    endfunction

    function automatic void clear_stats();
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i] = 0;
            xfer_wr[i] = 0;
            abort_cnt[i] = 0;
            wrap[i] = 1'b0;
            prev_da[i] = base_a[i];
            first_wa[i] = -1;
        end
        hi_run = 0;
        win_wr = 0;
    endfunction

    // advance the model by one enabled edge using the sampled inputs
    function automatic void model_edge(input int i);
        bit rise;
        bit fall;
        rise = VB && !m_vb[i];
        fall = !VB && m_vb[i];
        m_vb[i] = VB;
        e_we[i] = 1'b0;
        e_ab[i] = 1'b0;
        if (pend[i]) begin
            e_we[i] = 1'b1;
            e_oa[i] = pend_a[i];
            e_od[i] = int'(ram[e_da[i]]);
            pend[i] = 1'b0;
        end
        if (closing[i]) begin
            closing[i] = 1'b0;
        end else if (!want[i]) begin
            if (rise) want[i] = 1'b1;
        end else if (!own[i]) begin
            if (fall) begin
                want[i] = 1'b0;
                closing[i] = 1'b1;
                e_ab[i] = 1'b1;
            end else if (!busak_n) begin
                own[i] = 1'b1;
                iss[i] = 0;
            end
        end else if (iss[i] == len_a[i]) begin
            want[i] = 1'b0;
            own[i] = 1'b0;
            closing[i] = 1'b1;
        end else if (fall) begin
            want[i] = 1'b0;
            own[i] = 1'b0;
            closing[i] = 1'b1;
            e_ab[i] = 1'b1;
        end else if (!HBD_n && !busak_n) begin
            pend[i] = 1'b1;
            pend_a[i] = iss[i] % 256;
            e_da[i] = (base_a[i] + iss[i]) % 1024;
            iss[i]++;
        end
    endfunction

    task automatic compare(input int i);
        string s;
        s = $sformatf("u%0d", i);
        chk({s, "_busrq_n"}, int'(busrq_n_w[i]), int'(!want[i]));
        chk({s, "_DM10"}, int'(dm10_w[i]), int'(own[i]));
        chk({s, "_obj_we"}, int'(obj_we_w[i]), int'(e_we[i]));
        chk({s, "_abort"}, int'(abort_w[i]), int'(e_ab[i]));
        chk({s, "_dma_addr"}, int'(dma_addr_w[i]), e_da[i]);
        chk({s, "_obj_addr"}, int'(obj_addr_w[i]), e_oa[i]);
        chk({s, "_obj_dout"}, int'(obj_dout_w[i]), e_od[i]);
    endtask

    // rules checked straight from observed outputs
    task automatic observe(input int i);
        int a;
        if (obj_we_w[i]) begin
            a = int'(obj_addr_w[i]);
            chk($sformatf("u%0d_order", i), a, xfer_wr[i] % 256);
            chk($sformatf("u%0d_data", i), int'(obj_dout_w[i]),
                int'(ram[(base_a[i] + a) % 1024]));
            if (first_wa[i] < 0) first_wa[i] = a;
            xfer_wr[i]++;
            wr_cnt[i]++;
        end
        if (busrq_n_w[i] && !obj_we_w[i]) xfer_wr[i] = 0;
        if (abort_w[i]) abort_cnt[i]++;
        if (prev_da[i] == 'h3FF && dma_addr_w[i] == 10'h000) wrap[i] = 1'b1;
        prev_da[i] = int'(dma_addr_w[i]);
    endtask

    task automatic window_watch();
        if (HBD_n) begin
            hi_run++;
        end else begin
            if (hi_run > 0) begin
                chk("win_reads", int'(win_wr <= 8), 1);
                win_wr = 0;
            end
            hi_run = 0;
        end
        if (obj_we_w[0]) begin
            win_wr++;
            chk("late_write", int'(hi_run >= 2), 0);
        end
    endtask

    // one enabled clock edge, optionally preceded by disabled cycles
    task automatic step();
        int g;
        g = gap_en ? int'($urandom_range(0, 2)) : 0;
        if (g > 0) begin
            pxl_cen = 1'b0;
            repeat (g) @(posedge clk);
            #1;
        end
        pxl_cen = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            model_edge(i);
            compare(i);
            observe(i);
        end
        if (win_mode) window_watch();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_rst_busrq_n", i), int'(busrq_n_w[i]), 1);
            chk($sformatf("u%0d_rst_obj_we", i), int'(obj_we_w[i]), 0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        clear_stats();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int k = 0; k < 1024; k++) ram[k] = 8'($urandom);

        // vector table
        do_reset();
        chk("rst_dma_addr", int'(dma_addr_w[1]), 'h3C0);
        chk("rst_obj_addr", int'(obj_addr_w[0]), 0);
        for (int k = 0; k < 11; k++) begin
            VB = tbl[k].vb;
            HBD_n = tbl[k].hbd_n;
            busak_n = tbl[k].busak_n;
            step();
            chk($sformatf("tbl%0d_busrq_n", k), int'(busrq_n_w[0]),
                int'(tbl[k].busrq_n));
            chk($sformatf("tbl%0d_DM10", k), int'(dm10_w[0]),
                int'(tbl[k].dm10));
            chk($sformatf("tbl%0d_obj_we", k), int'(obj_we_w[0]),
                int'(tbl[k].we));
            chk($sformatf("tbl%0d_abort", k), int'(abort_w[0]),
                int'(tbl[k].abort));
        end

        // normal frame, both configurations
        VB = 1'b0; HBD_n = 1'b1; busak_n = 1'b1;
        do_reset();
        run(2);
        VB = 1'b1;
        step();
        chk("busrq_fall", int'(busrq_n_w[0]), 0);
        run(2);
        busak_n = 1'b0; HBD_n = 1'b0;
        run(290);
        VB = 1'b0;
        run(5);
        chk("norm_writes0", wr_cnt[0], 160);
        chk("norm_writes1", wr_cnt[1], 256);
        chk("norm_wrap1", int'(wrap[1]), 1);
        chk("norm_last_addr1", int'(obj_addr_w[1]), 255);
        chk("norm_busrq_n", int'(busrq_n_w[0]), 1);
        chk("norm_DM10", int'(dm10_w[0]), 0);

        // windowed transfer, 8 low / 56 high
        VB = 1'b0; HBD_n = 1'b1; busak_n = 1'b1;
        do_reset();
        gap_en = 1'b1;
        VB = 1'b1;
        run(3);
        busak_n = 1'b0;
        win_mode = 1'b1;
        for (int t = 0; t < 2200; t++) begin
            HBD_n = ((t % 64) < 8) ? 1'b0 : 1'b1;
            step();
        end
        win_mode = 1'b0;
        VB = 1'b0;
        run(5);
        chk("win_writes0", wr_cnt[0], 160);
        chk("win_writes1", wr_cnt[1], 256);
        gap_en = 1'b0;

        // abort after the 50th read
        VB = 1'b0; HBD_n = 1'b1; busak_n = 1'b1;
        do_reset();
        VB = 1'b1;
        run(2);
        busak_n = 1'b0; HBD_n = 1'b0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (iss[0] >= 50) break;
        end
        chk("abort_50th_addr", int'(dma_addr_w[0]), 49);
        VB = 1'b0;
        step();
        chk("abort_pulse", int'(abort_w[0]), 1);
        chk("abort_busrq_n", int'(busrq_n_w[0]), 1);
        run(3);
        chk("abort_writes", wr_cnt[0], 50);
        chk("abort_count", abort_cnt[0], 1);
        VB = 1'b1;
        step();
        chk("abort_idle_restart", int'(busrq_n_w[0]), 0);

        // late acknowledge
        VB = 1'b0; HBD_n = 1'b0; busak_n = 1'b1;
        do_reset();
        VB = 1'b1;
        run(20);
        VB = 1'b0;
        step();
        chk("late_abort_pulse", int'(abort_w[0]), 1);
        run(3);
        chk("late_writes", wr_cnt[0], 0);
        chk("late_abort_count", abort_cnt[0], 1);
        chk("late_busrq_n", int'(busrq_n_w[0]), 1);

        // reset in the middle of a transfer
        VB = 1'b0; HBD_n = 1'b1; busak_n = 1'b1;
        do_reset();
        VB = 1'b1;
        step();
        busak_n = 1'b0; HBD_n = 1'b0;
        run(30);
        chk("mid_pre_busrq_n", int'(busrq_n_w[0]), 0);
        do_reset();
        run(300);
        VB = 1'b0;
        run(5);
        chk("mid_first_addr", first_wa[0], 0);
        chk("mid_writes0", wr_cnt[0], 160);

        // random frames against the model
        VB = 1'b0; HBD_n = 1'b1; busak_n = 1'b1;
        do_reset();
        gap_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            bit stuck;
            stuck = ($urandom_range(0, 4) == 0);
            VB = 1'b0;
            for (int k = 0; k < int'($urandom_range(3, 10)); k++) begin
                HBD_n = 1'($urandom);
                busak_n = 1'($urandom);
                step();
            end
            VB = 1'b1;
            for (int k = 0; k < int'($urandom_range(50, 400)); k++) begin
                HBD_n = ($urandom_range(0, 3) == 0);
                busak_n = stuck ? 1'b1 : ($urandom_range(0, 7) == 0);
                step();
            end
        end
        VB = 1'b0;
        run(5);
        gap_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
